// File: rtl/nice_gemm_pkg.sv
// Shared types and decode helper for the NICE GEMM command front end.
package nice_gemm_pkg;

  localparam logic [6:0] OPC_CUSTOM1 = 7'b0101011;
  localparam logic [2:0] F3_CFG      = 3'b011;
  localparam logic [2:0] F3_START    = 3'b010;
  localparam logic [2:0] F3_STAT     = 3'b100;
  localparam int         SLOT_W      = 3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CFG_RSP = 2'd1,
    S_RUN     = 2'd2,
    S_RUN_RSP = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    K_ILL   = 2'd0,
    K_CFG   = 2'd1,
    K_START = 2'd2,
    K_STAT  = 2'd3
  } cmd_kind_e;

  typedef struct packed {
    cmd_kind_e         kind;
    logic [SLOT_W-1:0] slot;
  } dec_t;

  // Only an exact one-hot funct7 below num_cfg selects a slot; anything else is illegal.
  function automatic dec_t decode(input logic [31:0] instr, input int num_cfg, input int start_bit);
    dec_t       d;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc    = instr[6:0];
    f3     = instr[14:12];
    f7     = instr[31:25];
    d.kind = K_ILL;
    d.slot = '0;
    if (opc == OPC_CUSTOM1) begin
      case (f3)
        F3_CFG: begin
          for (int i = 0; i < 7; i++) begin
            if (i < num_cfg && f7 == 7'(1 << i)) begin
              d.kind = K_CFG;
              d.slot = SLOT_W'(i);
            end
          end
        end
        F3_START: if (f7 == 7'(1 << start_bit)) d.kind = K_START;
        F3_STAT:  d.kind = K_STAT;
        default:  d.kind = K_ILL;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/nice_gemm_cfg_bank.sv
// Bank of NUM_CFG {rs2,rs1} configuration slots, written one at a time by index.
module nice_gemm_cfg_bank
  import nice_gemm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_CFG = 6
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      we_i,
  input  logic [SLOT_W-1:0]         idx_i,
  input  logic [2*XLEN-1:0]         wdata_i,
  output logic [NUM_CFG*2*XLEN-1:0] cfg_o
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CFG; gi++) begin : g_slot
      logic [2*XLEN-1:0] slot_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          slot_q <= '0;
        end else if (we_i && idx_i == SLOT_W'(gi)) begin
          slot_q <= wdata_i;
        end
      end

      assign cfg_o[gi*2*XLEN +: 2*XLEN] = slot_q;
    end
  endgenerate

endmodule

// File: rtl/nice_gemm_cmd_ctrl.sv
// NICE custom-1 command controller: config slots, engine launch, cycle-count response.
// Optional watchdog enabled by defining GEMM_CMD_TIMEOUT_EN.
module nice_gemm_cmd_ctrl
  import nice_gemm_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int NUM_CFG     = 6,
  parameter int START_BIT   = 6,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                      nice_clk,
  input  logic                      nice_rst_n,
  input  logic                      nice_req_valid,
  output logic                      nice_req_ready,
  input  logic [31:0]               nice_req_instr,
  input  logic [XLEN-1:0]           nice_req_rs1,
  input  logic [XLEN-1:0]           nice_req_rs2,
  output logic                      nice_rsp_1cyc_type,
  output logic                      nice_rsp_multicyc_valid,
  input  logic                      nice_rsp_multicyc_ready,
  output logic [XLEN-1:0]           nice_rsp_multicyc_dat,
  output logic                      nice_rsp_multicyc_err,
  output logic                      nice_mem_holdup,
  output logic [NUM_CFG*2*XLEN-1:0] eng_cfg,
  output logic                      eng_start,
  input  logic                      eng_done,
  input  logic                      eng_err
);

`ifdef GEMM_CMD_TIMEOUT_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif
  localparam logic [XLEN-1:0] TO_LIMIT = XLEN'(TIMEOUT_CYC);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]   last_cnt_q, last_cnt_d;
  logic [XLEN-1:0]   rsp_dat_q, rsp_dat_d;
  logic              rsp_err_q, rsp_err_d;
  logic              sticky_q, sticky_d;
  logic              stat_rsp_q, stat_rsp_d;
  logic              start_q, start_d;
  logic              cfg_we;
  dec_t              dec;

  assign dec = decode(nice_req_instr, NUM_CFG, START_BIT);

  nice_gemm_cfg_bank #(
    .XLEN    (XLEN),
    .NUM_CFG (NUM_CFG)
  ) u_cfg_bank (
    .clk_i   (nice_clk),
    .rst_ni  (nice_rst_n),
    .we_i    (cfg_we),
    .idx_i   (dec.slot),
    .wdata_i ({nice_req_rs2, nice_req_rs1}),
    .cfg_o   (eng_cfg)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_cnt_d = last_cnt_q;
    rsp_dat_d  = rsp_dat_q;
    rsp_err_d  = rsp_err_q;
    sticky_d   = sticky_q;
    stat_rsp_d = stat_rsp_q;
    start_d    = 1'b0;
    cfg_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (nice_req_valid) begin
          stat_rsp_d = 1'b0;
          rsp_dat_d  = '0;
          rsp_err_d  = 1'b0;
          state_d    = S_CFG_RSP;
          case (dec.kind)
            K_CFG:   cfg_we = 1'b1;
            K_START: begin
              start_d = 1'b1;
              cnt_d   = '0;
              state_d = S_RUN;
            end
            K_STAT: begin
              rsp_dat_d  = last_cnt_q;
              rsp_err_d  = sticky_q;
              stat_rsp_d = 1'b1;
            end
            default: rsp_err_d = 1'b1;
          endcase
        end
      end
      S_CFG_RSP: begin
        if (nice_rsp_multicyc_ready) begin
          state_d = S_IDLE;
          if (stat_rsp_q) sticky_d = 1'b0;
        end
      end
      S_RUN: begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        // A done coincident with the launch pulse is stale from a previous run.
        if (eng_done && !start_q) begin
          rsp_dat_d  = cnt_q;
          rsp_err_d  = eng_err;
          last_cnt_d = cnt_q;
          if (eng_err) sticky_d = 1'b1;
          state_d = S_RUN_RSP;
        end else if (WDOG_EN && cnt_q == TO_LIMIT) begin
          rsp_dat_d = '1;
          rsp_err_d = 1'b1;
          sticky_d  = 1'b1;
          state_d   = S_RUN_RSP;
        end
      end
      S_RUN_RSP: begin
        if (nice_rsp_multicyc_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge nice_clk or negedge nice_rst_n) begin
    if (!nice_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_cnt_q <= '0;
      rsp_dat_q  <= '0;
      rsp_err_q  <= 1'b0;
      sticky_q   <= 1'b0;
      stat_rsp_q <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_cnt_q <= last_cnt_d;
      rsp_dat_q  <= rsp_dat_d;
      rsp_err_q  <= rsp_err_d;
      sticky_q   <= sticky_d;
      stat_rsp_q <= stat_rsp_d;
      start_q    <= start_d;
    end
  end

  assign nice_req_ready          = (state_q == S_IDLE);
  assign nice_rsp_1cyc_type      = 1'b0;
  assign nice_rsp_multicyc_valid = (state_q == S_CFG_RSP) || (state_q == S_RUN_RSP);
  assign nice_rsp_multicyc_dat   = rsp_dat_q;
  assign nice_rsp_multicyc_err   = rsp_err_q;
  assign nice_mem_holdup         = (state_q == S_RUN);
  assign eng_start               = start_q;

endmodule
